neuron_mac_acc: RTL and testbench

Streaming dot-product neuron that produces the pre-activation value for the activation stage (LRELU / sigmoid / tanh). It accepts one signed input/weight pair per handshake and accumulates N_IN products plus a bias in a wide accumulator. It then rounds, right-shifts to the output fixed-point scale and saturates to DATA_W. The result is presented on a valid/ready output whose data port connects directly to the activation input `x`.

---
 rtl/gan_fixed_pkg.sv | 41 ++++
 rtl/round_sat.sv | 25 ++
 rtl/neuron_mac_acc.sv | 169 ++++++++++++++++
 tb/tb_neuron_mac_acc.sv | 165 ++++++++++++++++
 4 files changed

// File: rtl/gan_fixed_pkg.sv
// Shared fixed-point helpers for the GAN datapath: state encoding, round-half-up
// constant and saturation to a narrower signed width.
package gan_fixed_pkg;

  typedef enum logic [1:0] {
    ACCUM = 2'd0,
    DRAIN = 2'd1,
    OUT   = 2'd2
  } state_e;

  localparam int EXT_W = 64;

  function automatic logic signed [EXT_W-1:0] round_half(input int shift);
    logic signed [EXT_W-1:0] half_v;
    if (shift > 0) begin
      half_v = 64'sd1 <<< (shift - 1);
    end else begin
      half_v = 64'sd0;
    end
    return half_v;
  endfunction

  // Clip v into the range of a w-bit signed number; result stays EXT_W wide.
  function automatic logic signed [EXT_W-1:0] sat_to_width(input logic signed [EXT_W-1:0] v,
                                                           input int w);
    logic signed [EXT_W-1:0] hi_v;
    logic signed [EXT_W-1:0] lo_v;
    logic signed [EXT_W-1:0] res_v;
    hi_v = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo_v = -(64'sd1 <<< (w - 1));
    if (v > hi_v) begin
      res_v = hi_v;
    end else if (v < lo_v) begin
      res_v = lo_v;
    end else begin
      res_v = v;
    end
    return res_v;
  endfunction

endpackage

// File: rtl/round_sat.sv
// Combinational round-half-up, arithmetic right shift and saturation from the
// accumulator width down to DATA_W, with a clip flag.
module round_sat
  import gan_fixed_pkg::*;
#(
  parameter int ACC_W  = 40,
  parameter int DATA_W = 16,
  parameter int SHIFT  = 8
) (
  input  logic signed [ACC_W-1:0]  s,
  output logic signed [DATA_W-1:0] y,
  output logic                     sat
);

  logic signed [EXT_W-1:0] s_ext_s;
  logic signed [EXT_W-1:0] rnd_s;
  logic signed [EXT_W-1:0] clip_s;

  assign s_ext_s = {{(EXT_W-ACC_W){s[ACC_W-1]}}, s};
  assign rnd_s   = (s_ext_s + round_half(SHIFT)) >>> SHIFT;
  assign clip_s  = sat_to_width(rnd_s, DATA_W);
  assign y       = clip_s[DATA_W-1:0];
  assign sat     = (clip_s != rnd_s);

endmodule

// File: rtl/neuron_mac_acc.sv
// Streaming dot-product neuron: accumulates N_IN signed products plus a bias,
// then rounds/saturates to DATA_W and presents the result on a valid/ready port.
module neuron_mac_acc
  import gan_fixed_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int N_IN   = 16,
  parameter int ACC_W  = 40,
  parameter int SHIFT  = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic signed [DATA_W-1:0] in_x,
  input  logic signed [DATA_W-1:0] in_w,
  input  logic signed [DATA_W-1:0] bias,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic signed [DATA_W-1:0] out_y,
  output logic                     out_sat
);

  localparam int PROD_W = 2 * DATA_W;
  localparam int CNT_W  = (N_IN > 1) ? $clog2(N_IN) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(N_IN - 1);

  generate
    if ((ACC_W < 2 * DATA_W + $clog2(N_IN) + 1) || (ACC_W >= EXT_W)) begin : g_acc_w_bad
      $error("neuron_mac_acc: ACC_W out of range for DATA_W/N_IN");
    end
    if ((SHIFT < 0) || (SHIFT >= 2 * DATA_W) || (N_IN < 1)) begin : g_param_bad
      $error("neuron_mac_acc: SHIFT or N_IN out of range");
    end
  endgenerate

  state_e                    state_r;
  state_e                    next_state_s;
  logic [CNT_W-1:0]          cnt_r;
  logic signed [PROD_W-1:0]  prod_r;
  logic                      prod_vld_r;
  logic signed [ACC_W-1:0]   acc_r;
  logic signed [DATA_W-1:0]  bias_r;
  logic                      beat_s;
  logic                      in_ready_s;
  logic                      out_valid_s;
  logic signed [ACC_W-1:0]   prod_ext_s;
  logic signed [ACC_W-1:0]   prod_add_s;
  logic signed [ACC_W-1:0]   bias_sh_s;
  logic signed [ACC_W-1:0]   sum_s;
  logic signed [DATA_W-1:0]  y_s;
  logic                      sat_s;

  assign beat_s = in_valid && in_ready;

  // State register plus the registered handshake outputs decoded from next state.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r   <= ACCUM;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
    end else begin
      state_r   <= next_state_s;
      in_ready  <= in_ready_s;
      out_valid <= out_valid_s;
    end
  end

  // Next-state decode.
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      ACCUM: begin
        if (beat_s && (cnt_r == LAST)) begin
          next_state_s = DRAIN;
        end else begin
          next_state_s = ACCUM;
        end
      end
      DRAIN: next_state_s = OUT;
      OUT: begin
        if (out_ready) begin
          next_state_s = ACCUM;
        end else begin
          next_state_s = OUT;
        end
      end
      default: next_state_s = ACCUM;
    endcase
  end

  // Output decode from the upcoming state so the handshake flags are registered.
  always_comb begin
    in_ready_s  = (next_state_s == ACCUM);
    out_valid_s = (next_state_s == OUT);
  end

  // Final sum: the last product is still pending in prod_r during DRAIN.
  always_comb begin
    prod_ext_s = {{(ACC_W-PROD_W){prod_r[PROD_W-1]}}, prod_r};
    if (prod_vld_r) begin
      prod_add_s = prod_ext_s;
    end else begin
      prod_add_s = {ACC_W{1'b0}};
    end
    bias_sh_s = {{(ACC_W-DATA_W){bias_r[DATA_W-1]}}, bias_r};
    bias_sh_s = bias_sh_s <<< SHIFT;
    sum_s     = acc_r + prod_add_s + bias_sh_s;
  end

  round_sat #(
    .ACC_W (ACC_W),
    .DATA_W(DATA_W),
    .SHIFT (SHIFT)
  ) u_round_sat (
    .s  (sum_s),
    .y  (y_s),
    .sat(sat_s)
  );

  // Product pipeline, accumulator, beat counter, bias capture and result registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_r      <= {CNT_W{1'b0}};
      prod_r     <= {PROD_W{1'b0}};
      prod_vld_r <= 1'b0;
      acc_r      <= {ACC_W{1'b0}};
      bias_r     <= {DATA_W{1'b0}};
      out_y      <= {DATA_W{1'b0}};
      out_sat    <= 1'b0;
    end else begin
      case (state_r)
        ACCUM: begin
          prod_vld_r <= beat_s;
          if (beat_s) begin
            prod_r <= PROD_W'(in_x) * PROD_W'(in_w);
            if (cnt_r == LAST) begin
              cnt_r <= {CNT_W{1'b0}};
            end else begin
              cnt_r <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
            end
          end else begin
            cnt_r <= cnt_r;
          end
          if (beat_s && (cnt_r == {CNT_W{1'b0}})) begin
            acc_r  <= {ACC_W{1'b0}};
            bias_r <= bias;
          end else if (prod_vld_r) begin
            acc_r <= acc_r + prod_ext_s;
          end else begin
            acc_r <= acc_r;
          end
        end
        DRAIN: begin
          prod_vld_r <= 1'b0;
          out_y      <= y_s;
          out_sat    <= sat_s;
        end
        OUT: begin
          prod_vld_r <= 1'b0;
        end
        default: begin
          prod_vld_r <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_neuron_mac_acc.sv
// Directed self-checking bench for neuron_mac_acc (DATA_W=16, N_IN=4, ACC_W=40, SHIFT=8).
module tb_neuron_mac_acc;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               in_valid = 1'b0;
  logic               in_ready;
  logic signed [15:0] in_x = 16'sd0;
  logic signed [15:0] in_w = 16'sd0;
  logic signed [15:0] bias = 16'sd0;
  logic               out_valid;
  logic               out_ready = 1'b1;
  logic signed [15:0] out_y;
  logic               out_sat;

  int checks = 0;
  int errors = 0;

  neuron_mac_acc #(
    .DATA_W(16),
    .N_IN  (4),
    .ACC_W (40),
    .SHIFT (8)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_x     (in_x),
    .in_w     (in_w),
    .bias     (bias),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_y    (out_y),
    .out_sat  (out_sat)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic beat(input logic signed [15:0] x, input logic signed [15:0] w,
                      input logic signed [15:0] b);
    in_valid = 1'b1;
    in_x     = x;
    in_w     = w;
    bias     = b;
    step();
  endtask

  task automatic send_uniform(input logic signed [15:0] x, input logic signed [15:0] w,
                              input logic signed [15:0] b);
    for (int i = 0; i < 4; i++) beat(x, w, b);
    in_valid = 1'b0;
  endtask

  // Called right after the edge that accepted the last beat, with out_ready=1.
  task automatic expect_out(input string tag, input logic signed [31:0] y, input logic signed [31:0] s);
    chk({tag, "_drain_valid"}, out_valid, 0);
    chk({tag, "_drain_ready"}, in_ready, 0);
    step();
    chk({tag, "_valid"}, out_valid, 1);
    chk({tag, "_y"}, out_y, y);
    chk({tag, "_sat"}, out_sat, s);
    step();
    chk({tag, "_done_valid"}, out_valid, 0);
    chk({tag, "_done_ready"}, in_ready, 1);
  endtask

  initial begin
    rst_n = 1'b0;
    step();
    step();
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_y", out_y, 0);
    chk("rst_out_sat", out_sat, 0);
    rst_n = 1'b1;

    send_uniform(16'sd256, 16'sd256, 16'sd0);
    expect_out("unity", 1024, 0);

    // bias sampled on first beat only; later bias values must be ignored
    beat(16'sd256, 16'sd256, -16'sd24);
    beat(16'sd256, 16'sd256, 16'sd77);
    in_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("gap_ready", in_ready, 1);
      chk("gap_valid", out_valid, 0);
    end
    beat(16'sd256, 16'sd256, 16'sd77);
    beat(16'sd256, 16'sd256, 16'sd77);
    in_valid = 1'b0;
    expect_out("bias_gap", 1000, 0);

    send_uniform(16'sd32767, 16'sd32767, 16'sd0);
    expect_out("sat_pos", 32767, 1);
    send_uniform(-16'sd32768, 16'sd32767, 16'sd0);
    expect_out("sat_neg", -32768, 1);

    beat(16'sd1, 16'sd128, 16'sd0);
    for (int i = 0; i < 3; i++) beat(16'sd0, 16'sd0, 16'sd0);
    in_valid = 1'b0;
    expect_out("round_pos", 1, 0);
    beat(-16'sd1, 16'sd129, 16'sd0);
    for (int i = 0; i < 3; i++) beat(16'sd0, 16'sd0, 16'sd0);
    in_valid = 1'b0;
    expect_out("round_neg", -1, 0);

    // backpressure: hold result for 5 cycles while junk beats are offered
    out_ready = 1'b0;
    send_uniform(16'sd256, 16'sd256, 16'sd0);
    step();
    chk("bp_valid0", out_valid, 1);
    chk("bp_y0", out_y, 1024);
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      in_x     = 16'sd1000;
      in_w     = 16'sd1000;
      bias     = 16'sd500;
      step();
      chk("bp_valid", out_valid, 1);
      chk("bp_y", out_y, 1024);
      chk("bp_sat", out_sat, 0);
      chk("bp_ready", in_ready, 0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    step();
    chk("bp_hs_valid", out_valid, 0);
    chk("bp_hs_ready", in_ready, 1);
    send_uniform(16'sd256, 16'sd256, -16'sd24);
    expect_out("bp_next", 1000, 0);

    // reset mid-vector discards the partial sum and the beat count
    beat(16'sd32767, 16'sd32767, 16'sd100);
    beat(16'sd32767, 16'sd32767, 16'sd100);
    in_valid = 1'b0;
    rst_n    = 1'b0;
    step();
    rst_n = 1'b1;
    chk("mrst_in_ready", in_ready, 1);
    chk("mrst_out_valid", out_valid, 0);
    chk("mrst_out_y", out_y, 0);
    chk("mrst_out_sat", out_sat, 0);
    send_uniform(16'sd256, 16'sd256, 16'sd0);
    expect_out("mrst_unity", 1024, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
